// File: rtl/gcd_pkg.sv
// Shared types and default parameters for the binary GCD unit.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STRIP  = 3'd1,
    REDUCE = 3'd2,
    SHIFT  = 3'd3,
    DONE   = 3'd4
  } gcd_state_t;

  localparam int GCD_W_DEFAULT  = 128;
  localparam int GCD_CW_DEFAULT = 16;

endpackage

// File: rtl/gcd_binary_step.sv
// One REDUCE step of Stein's algorithm: the first matching rule wins.
// Subtraction is always larger minus smaller, so it never wraps.
module gcd_binary_step #(
  parameter int W = 128
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] next_a,
  output logic [W-1:0] next_b,
  output logic         equal
);

  assign equal = (a == b);

  // Select the single reduction applied this cycle, in rule priority order.
  always_comb begin
    next_a = a;
    next_b = b;
    if (equal) begin
      next_a = a;
      next_b = b;
    end else if (a[0] == 1'b0) begin
      next_a = a >> 1;
    end else if (b[0] == 1'b0) begin
      next_b = b >> 1;
    end else if (a > b) begin
      next_a = (a - b) >> 1;
    end else begin
      next_b = (b - a) >> 1;
    end
  end

endmodule

// File: rtl/gcd_binary.sv
// Binary (Stein) GCD with valid/ready operand and result ports.
// One computation at a time; the busy-cycle count saturates at 2^CW-1.
module gcd_binary
  import gcd_pkg::*;
#(
  parameter int W  = GCD_W_DEFAULT,
  parameter int CW = GCD_CW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_gcd,
  output logic [CW-1:0] out_cycles
);

  localparam int KW = $clog2(W);
  localparam logic [KW-1:0] K_ONE   = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  gcd_state_t    state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [KW-1:0] k_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  out_gcd_q;
  logic [CW-1:0] out_cycles_q;

  logic [W-1:0]  step_a_d;
  logic [W-1:0]  step_b_d;
  logic          equal_d;
  logic [CW-1:0] cnt_d;
  logic [W-1:0]  shifted_d;

  gcd_binary_step #(.W(W)) u_step (
    .a      (a_q),
    .b      (b_q),
    .next_a (step_a_d),
    .next_b (step_b_d),
    .equal  (equal_d)
  );

  // Saturating busy-cycle increment and final power-of-two restore.
  always_comb begin
    cnt_d     = cnt_q;
    shifted_d = a_q << k_q;
    if (cnt_q != {CW{1'b1}}) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      k_q          <= '0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_gcd_q    <= '0;
      out_cycles_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            k_q        <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (in_a == '0) begin
              out_gcd_q    <= in_b;
              out_cycles_q <= '0;
              out_valid_q  <= 1'b1;
              state_q      <= DONE;
            end else if (in_b == '0) begin
              out_gcd_q    <= in_a;
              out_cycles_q <= '0;
              out_valid_q  <= 1'b1;
              state_q      <= DONE;
            end else begin
              state_q <= STRIP;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        STRIP: begin
          cnt_q <= cnt_d;
          if ((a_q[0] == 1'b0) && (b_q[0] == 1'b0)) begin
            a_q <= a_q >> 1;
            b_q <= b_q >> 1;
            k_q <= k_q + K_ONE;
          end else begin
            state_q <= REDUCE;
          end
        end
        REDUCE: begin
          cnt_q <= cnt_d;
          if (equal_d) begin
            state_q <= SHIFT;
          end else begin
            a_q <= step_a_d;
            b_q <= step_b_d;
          end
        end
        SHIFT: begin
          cnt_q        <= cnt_d;
          a_q          <= shifted_d;
          out_gcd_q    <= shifted_d;
          out_cycles_q <= cnt_d;
          out_valid_q  <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_gcd    = out_gcd_q;
  assign out_cycles = out_cycles_q;

endmodule

// File: tb/tb_gcd_binary.sv
// Directed scoreboard bench for gcd_binary at W=8.
module tb_gcd_binary;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_gcd;
  logic [CW-1:0] out_cycles;

  typedef struct {
    logic [W-1:0]  g;
    logic [CW-1:0] c;
    bit            chk_c;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  gcd_binary #(.W(W), .CW(CW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_cycles (out_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one operand pair; returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Wait for the result (bounded), pop the scoreboard and compare.
  task automatic collect(input string tag);
    int lat;
    exp_t e;
    lat = 1;
    while (!out_valid && lat < 300) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_gcd"}, {24'd0, out_gcd}, {24'd0, e.g});
      if (e.chk_c) begin
        check({tag, "_cycles"}, {16'd0, out_cycles}, {16'd0, e.c});
        check({tag, "_latency"}, lat, {16'd0, e.c} + 32'd1);
      end
    end
  endtask

  task automatic handover(input string tag);
    @(negedge clock);
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [CW-1:0] c, input bit chk_c);
    exp_t e;
    e.g = ref_gcd(a, b);
    e.c = c;
    e.chk_c = chk_c;
    sb.push_back(e);
    send(a, b);
    collect(tag);
    handover(tag);
  endtask

  initial begin
    exp_t e;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_gcd", {24'd0, out_gcd}, 32'd0);
    check("rst_cycles", {16'd0, out_cycles}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    run_op("g12_18", 8'd12, 8'd18, 16'd6, 1'b1);
    run_op("g7_7", 8'd7, 8'd7, 16'd3, 1'b1);
    run_op("g0_45", 8'd0, 8'd45, 16'd0, 1'b1);
    run_op("g45_0", 8'd45, 8'd0, 16'd0, 1'b1);
    run_op("g0_0", 8'd0, 8'd0, 16'd0, 1'b1);
    run_op("g128_128", 8'd128, 8'd128, 16'd10, 1'b1);
    run_op("g255_1", 8'd255, 8'd1, 16'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_op("rand", 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 16'd0, 1'b0);
    end

    // Back-pressure on gcd(35,21)=7, 5 busy cycles.
    out_ready = 1'b0;
    e.g = 8'd7;
    e.c = 16'd5;
    e.chk_c = 1'b1;
    sb.push_back(e);
    send(8'd35, 8'd21);
    collect("bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1 || i == 2);
      in_a = 8'd100;
      in_b = 8'd50;
      @(negedge clock);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_gcd", {24'd0, out_gcd}, 32'd7);
      check("bp_hold_cycles", {16'd0, out_cycles}, 32'd5);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    handover("bp");
    repeat (3) begin
      @(negedge clock);
      check("bp_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    // Reset abort while in REDUCE: accept edge, STRIP edge, then REDUCE.
    send(8'd35, 8'd21);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_gcd", {24'd0, out_gcd}, 32'd0);
    check("abort_cycles", {16'd0, out_cycles}, 32'd0);
    run_op("g9_6", 8'd9, 8'd6, 16'd5, 1'b1);
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
